itrx_aib_phy_tap_ctrl: RTL and testbench

IEEE 1149.1 TAP controller for the AIB PHY JTAG path. It runs the 16-state TAP FSM and shifts the instruction register. It publishes the IR on Update-IR as ir_latched to the downstream AIB private-instruction decoder. It also owns the BYPASS and IDCODE data registers and muxes TDO among IR, BYPASS, IDCODE and the external boundary-scan chain.

---
 rtl/itrx_aib_phy_tap_ctrl.sv | 177 +++++++++++++++++
 tb/tb_itrx_aib_phy_tap_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/itrx_aib_phy_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the AIB PHY JTAG path.
// Runs the 16-state TAP FSM and owns the IR, BYPASS and IDCODE registers.
// TDO is muxed among IR, BYPASS, IDCODE and the external boundary-scan chain.
// ir_latched feeds the downstream AIB private-instruction decoder.
module itrx_aib_phy_tap_ctrl #(
  parameter int unsigned                LATCHED_IR_WID = 7,
  parameter logic [31:0]                IDCODE_VAL     = 32'h0000_0001,
  parameter logic [LATCHED_IR_WID-1:0]  INST_IDCODE    = 7'b000_0001,
  parameter logic [LATCHED_IR_WID-1:0]  INST_BYPASS    = 7'b111_1111,
  parameter logic [LATCHED_IR_WID-1:0]  INST_EXTEST    = 7'b000_0000
) (
  input  logic                      tck,
  input  logic                      reset,
  input  logic                      tms,
  input  logic                      tdi,
  input  logic                      chain_tdo,
  output logic                      tdo,
  output logic                      tdo_en,
  output logic [LATCHED_IR_WID-1:0] ir_latched,
  output logic                      tlr,
  output logic                      chain_capture,
  output logic                      chain_shift,
  output logic                      chain_update
);

  typedef enum logic [3:0] {
    ST_TLR     = 4'd0,
    ST_RTI     = 4'd1,
    ST_SEL_DR  = 4'd2,
    ST_CAP_DR  = 4'd3,
    ST_SH_DR   = 4'd4,
    ST_EX1_DR  = 4'd5,
    ST_PA_DR   = 4'd6,
    ST_EX2_DR  = 4'd7,
    ST_UPD_DR  = 4'd8,
    ST_SEL_IR  = 4'd9,
    ST_CAP_IR  = 4'd10,
    ST_SH_IR   = 4'd11,
    ST_EX1_IR  = 4'd12,
    ST_PA_IR   = 4'd13,
    ST_EX2_IR  = 4'd14,
    ST_UPD_IR  = 4'd15
  } tap_state_t;

  // Capture-IR pattern: LSB=1, bit1=0, remaining bits 0.
  localparam logic [LATCHED_IR_WID-1:0] IR_CAPTURE = {{(LATCHED_IR_WID-1){1'b0}}, 1'b1};

  tap_state_t                state_r;
  tap_state_t                state_nxt_s;
  logic [LATCHED_IR_WID-1:0] ir_shift_r;
  logic [LATCHED_IR_WID-1:0] ir_shift_nxt_s;
  logic [LATCHED_IR_WID-1:0] ir_latched_r;
  logic [LATCHED_IR_WID-1:0] ir_latched_nxt_s;
  logic                      bypass_r;
  logic                      bypass_nxt_s;
  logic [31:0]               idcode_r;
  logic [31:0]               idcode_nxt_s;
  logic                      tdo_r;
  logic                      tdo_nxt_s;
  logic                      sel_idcode_s;
  logic                      sel_extest_s;

  // DR select: IDCODE and EXTEST are decoded; everything else (BYPASS and
  // the AIB private opcodes) falls through to the bypass register.
  assign sel_idcode_s = (ir_latched_r == INST_IDCODE);
  assign sel_extest_s = (ir_latched_r == INST_EXTEST) && !sel_idcode_s;

  // TAP state transitions on tms.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_TLR:    state_nxt_s = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    state_nxt_s = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_nxt_s = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_nxt_s = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_nxt_s = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_nxt_s = tms ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_nxt_s = tms ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_nxt_s = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_nxt_s = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_nxt_s = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_nxt_s = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_nxt_s = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_nxt_s = tms ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_nxt_s = tms ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_nxt_s = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_nxt_s = tms ? ST_SEL_DR : ST_RTI;
      default:   state_nxt_s = ST_TLR;
    endcase
  end

  // Next values of the IR, latched IR and data registers for this edge.
  always_comb begin
    ir_shift_nxt_s   = ir_shift_r;
    ir_latched_nxt_s = ir_latched_r;
    bypass_nxt_s     = bypass_r;
    idcode_nxt_s     = idcode_r;

    case (state_r)
      ST_CAP_IR: ir_shift_nxt_s = IR_CAPTURE;
      ST_SH_IR:  ir_shift_nxt_s = {tdi, ir_shift_r[LATCHED_IR_WID-1:1]};
      default:   ir_shift_nxt_s = ir_shift_r;
    endcase

    // Entering (or staying in) TLR always wins over an Update-IR copy.
    if (state_nxt_s == ST_TLR) begin
      ir_latched_nxt_s = INST_IDCODE;
    end else if (state_r == ST_UPD_IR) begin
      ir_latched_nxt_s = ir_shift_r;
    end else begin
      ir_latched_nxt_s = ir_latched_r;
    end

    if (sel_idcode_s) begin
      case (state_r)
        ST_CAP_DR: idcode_nxt_s = IDCODE_VAL;
        ST_SH_DR:  idcode_nxt_s = {tdi, idcode_r[31:1]};
        default:   idcode_nxt_s = idcode_r;
      endcase
    end else if (!sel_extest_s) begin
      case (state_r)
        ST_CAP_DR: bypass_nxt_s = 1'b0;
        ST_SH_DR:  bypass_nxt_s = tdi;
        default:   bypass_nxt_s = bypass_r;
      endcase
    end else begin
      idcode_nxt_s = idcode_r;
      bypass_nxt_s = bypass_r;
    end
  end

  // TDO source: the LSB that will be presented once the next shift state is entered.
  always_comb begin
    tdo_nxt_s = tdo_r;
    if (state_nxt_s == ST_SH_IR) begin
      tdo_nxt_s = ir_shift_nxt_s[0];
    end else if (state_nxt_s == ST_SH_DR) begin
      if (sel_extest_s) begin
        tdo_nxt_s = chain_tdo;
      end else if (sel_idcode_s) begin
        tdo_nxt_s = idcode_nxt_s[0];
      end else begin
        tdo_nxt_s = bypass_nxt_s;
      end
    end else begin
      tdo_nxt_s = tdo_r;
    end
  end

  // State and register update; reset has priority over tms.
  always_ff @(posedge tck) begin
    if (reset) begin
      state_r      <= ST_TLR;
      ir_shift_r   <= {LATCHED_IR_WID{1'b0}};
      ir_latched_r <= INST_IDCODE;
      bypass_r     <= 1'b0;
      idcode_r     <= IDCODE_VAL;
      tdo_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ir_shift_r   <= ir_shift_nxt_s;
      ir_latched_r <= ir_latched_nxt_s;
      bypass_r     <= bypass_nxt_s;
      idcode_r     <= idcode_nxt_s;
      tdo_r        <= tdo_nxt_s;
    end
  end

  assign tdo           = tdo_r;
  assign ir_latched    = ir_latched_r;
  assign tlr           = (state_r == ST_TLR);
  assign tdo_en        = (state_r == ST_SH_IR) || (state_r == ST_SH_DR);
  assign chain_capture = (state_r == ST_CAP_DR) && sel_extest_s;
  assign chain_shift   = (state_r == ST_SH_DR)  && sel_extest_s;
  assign chain_update  = (state_r == ST_UPD_DR) && sel_extest_s;

endmodule

// File: tb/tb_itrx_aib_phy_tap_ctrl.sv
// Directed self-checking bench for itrx_aib_phy_tap_ctrl.
module tb_itrx_aib_phy_tap_ctrl;

  localparam logic [31:0] IDV = 32'hA5C3_0F1B;

  logic       tck;
  logic       reset;
  logic       tms;
  logic       tdi;
  logic       chain_tdo;
  logic       tdo;
  logic       tdo_en;
  logic [6:0] ir_latched;
  logic       tlr;
  logic       chain_capture;
  logic       chain_shift;
  logic       chain_update;

  int n_tests = 0;
  int n_fail  = 0;

  itrx_aib_phy_tap_ctrl #(.IDCODE_VAL(IDV)) dut (
    .tck           (tck),
    .reset         (reset),
    .tms           (tms),
    .tdi           (tdi),
    .chain_tdo     (chain_tdo),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .ir_latched    (ir_latched),
    .tlr           (tlr),
    .chain_capture (chain_capture),
    .chain_shift   (chain_shift),
    .chain_update  (chain_update)
  );

  // 100 MHz JTAG clock
  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One TCK cycle; outputs are sampled 1 ns after the rising edge.
  task automatic tick(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tck);
    #1;
  endtask

  // From RTI, walk into Shift-IR (capture edge included).
  task automatic goto_shift_ir();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI, walk into Shift-DR (capture edge included).
  task automatic goto_shift_dr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // Load an IR value from RTI, checking the capture pattern and Update-IR timing.
  task automatic load_ir(input logic [6:0] val);
    logic [6:0] cap;
    logic [6:0] old_ir;
    cap    = 7'b000_0001;
    old_ir = ir_latched;
    goto_shift_ir();
    for (int i = 0; i < 7; i++) begin
      check_val("ir_tdo_en", {31'd0, tdo_en}, 32'd1);
      check_val($sformatf("ir_cap_bit%0d", i), {31'd0, tdo}, {31'd0, cap[i]});
      tick(i == 6, val[i]);
    end
    tick(1'b1, 1'b0);
    check_val("ir_before_upd", {25'd0, ir_latched}, {25'd0, old_ir});
    tick(1'b0, 1'b0);
    check_val("ir_after_upd", {25'd0, ir_latched}, {25'd0, val});
  endtask

  initial begin
    logic [7:0] bp;
    logic [6:0] cp;
    bp        = 8'b0100_1101;
    cp        = 7'b101_1001;
    reset     = 1'b1;
    tms       = 1'b1;
    tdi       = 1'b0;
    chain_tdo = 1'b0;

    // Reset state
    @(posedge tck); #1;
    @(posedge tck); #1;
    check_val("rst_tlr", {31'd0, tlr}, 32'd1);
    check_val("rst_ir", {25'd0, ir_latched}, 32'h01);
    check_val("rst_tdo", {31'd0, tdo}, 32'd0);
    check_val("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
    reset = 1'b0;

    // TLR -> RTI
    tick(1'b0, 1'b0);
    check_val("rti_tlr", {31'd0, tlr}, 32'd0);
    check_val("rti_ir", {25'd0, ir_latched}, 32'h01);

    // IDCODE readout
    goto_shift_dr();
    for (int i = 0; i < 32; i++) begin
      check_val($sformatf("idc_bit%0d", i), {31'd0, tdo}, {31'd0, IDV[i]});
      tick(i == 31, 1'b0);
    end
    check_val("idc_exit_tdo_en", {31'd0, tdo_en}, 32'd0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // Private opcode 0x0C through the IR
    load_ir(7'h0C);

    // BYPASS: one-bit delay, first bit 0
    load_ir(7'h7F);
    goto_shift_dr();
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("byp_bit%0d", i), {31'd0, tdo}, (i == 0) ? 32'd0 : {31'd0, bp[i-1]});
      tick(i == 7, bp[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // EXTEST: chain strobes and chain_tdo passthrough
    load_ir(7'h00);
    tick(1'b1, 1'b0);
    check_val("ext_cap_pre", {31'd0, chain_capture}, 32'd0);
    tick(1'b0, 1'b0);
    check_val("ext_cap", {31'd0, chain_capture}, 32'd1);
    check_val("ext_sh_in_cap", {31'd0, chain_shift}, 32'd0);
    chain_tdo = cp[0];
    tick(1'b0, 1'b0);
    check_val("ext_cap_post", {31'd0, chain_capture}, 32'd0);
    check_val("ext_tdo0", {31'd0, tdo}, {31'd0, cp[0]});
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("ext_shift%0d", i), {31'd0, chain_shift}, 32'd1);
      chain_tdo = cp[i+1];
      tick(i == 5, 1'b0);
      if (i < 5) check_val($sformatf("ext_tdo%0d", i + 1), {31'd0, tdo}, {31'd0, cp[i+1]});
    end
    check_val("ext_exit_shift", {31'd0, chain_shift}, 32'd0);
    check_val("ext_exit_hold", {31'd0, tdo}, {31'd0, cp[5]});
    check_val("ext_upd_pre", {31'd0, chain_update}, 32'd0);
    tick(1'b1, 1'b0);
    check_val("ext_upd", {31'd0, chain_update}, 32'd1);
    tick(1'b0, 1'b0);
    check_val("ext_upd_post", {31'd0, chain_update}, 32'd0);

    // Five tms=1 edges from mid Shift-IR reach TLR
    goto_shift_ir();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check_val("tms5_tlr", {31'd0, tlr}, 32'd1);
    check_val("tms5_ir", {25'd0, ir_latched}, 32'h01);
    tick(1'b0, 1'b0);

    // Reset mid Shift-IR
    load_ir(7'h0C);
    goto_shift_ir();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    check_val("rstmid_tlr", {31'd0, tlr}, 32'd1);
    check_val("rstmid_ir", {25'd0, ir_latched}, 32'h01);
    check_val("rstmid_tdo_en", {31'd0, tdo_en}, 32'd0);
    tick(1'b0, 1'b0);
    check_val("rstmid_rti_ir", {25'd0, ir_latched}, 32'h01);

    // IDCODE readout with a 3-cycle Pause-DR after bit 12
    goto_shift_dr();
    for (int i = 0; i < 32; i++) begin
      check_val($sformatf("pau_bit%0d", i), {31'd0, tdo}, {31'd0, IDV[i]});
      if (i == 12) begin
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_val("pau_tdo_en", {31'd0, tdo_en}, 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check_val("pau_resume_en", {31'd0, tdo_en}, 32'd1);
      end else begin
        tick(i == 31, 1'b0);
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
